alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single registered 32-bit ALU between two requesters: req0 (execute stage) and req1 (branch/compare unit).
//  Arbitrates between them, drives the ALU operand/opcode inputs, and tracks the ALU's 1-cycle registered latency.
//  Captures R/ovf/zero/branch and returns them with a requester id over a valid/ready response channel.
//  Sits between the pipeline front-ends and the ALU instance.
// PARAMETERS
//  WIDTH      32      operand/result width; must match the ALU datapath
//  CTRL_W     3       ALU opcode width
//  IDLE_CTRL  3'b111  opcode driven while idle; the ALU's default case makes R=0
// PORTS
//  clk         in   1       rising-edge clock, shared with ALU
//  reset       in   1       asynchronous, active-high; also routed to ALU reset
//  req0_valid  in   1       requester 0 has an operation
//  req0_ready  out  1       requester 0 operation accepted this cycle
//  req0_a      in   WIDTH   requester 0 operand A
//  req0_b      in   WIDTH   requester 0 operand B
//  req0_ctrl   in   CTRL_W  requester 0 ALU opcode
//  req1_*      -    -       same set as req0_* for requester 1
//  alu_a       out  WIDTH   to ALU A, registered
//  alu_b       out  WIDTH   to ALU B, registered
//  alu_ctrl    out  CTRL_W  to ALU CTRL, registered
//  alu_r       in   WIDTH   from ALU R
//  alu_zero    in   1       from ALU zero
//  alu_ovf     in   1       from ALU ovf
//  alu_branch  in   1       from ALU branch
//  rsp_valid   out  1       response held valid
//  rsp_ready   in   1       consumer accepts response
//  rsp_id      out  1       0 = req0, 1 = req1
//  rsp_r       out  WIDTH   captured result
//  rsp_zero    out  1       captured zero flag
//  rsp_ovf     out  1       captured overflow flag
//  rsp_branch  out  1       captured branch flag
// BEHAVIOUR
//  Reset (async): state=IDLE; alu_a=alu_b=0; alu_ctrl=IDLE_CTRL; rsp_valid=0; rsp_id=0; rsp_r=0;
//    all rsp flags 0; last_grant=1, so req0 wins the first tie.
//  FSM states:
//    IDLE -> EXEC  on any reqX_valid (grant edge)
//    EXEC -> CAPT  unconditionally (ALU samples operands on this edge)
//    CAPT -> RESP  unconditionally (arbiter captures alu_r/zero/ovf/branch into rsp_*)
//    RESP -> IDLE  when rsp_ready; otherwise hold
//  Arbitration in IDLE only; reqX_ready is combinational.
//    Exactly one reqX_ready is high in IDLE when any valid is high; both are 0 in all other states.
//    Only one requester valid: it is granted.
//    Both valid: round-robin; grant the requester != last_grant. last_grant updates on the grant edge.
//  Grant edge: alu_a/alu_b/alu_ctrl <= granted operands; rsp_id <= granted id.
//    reqX_* are sampled only on the grant edge; they may change afterwards.
//  Latency: accept at edge E0 -> ALU computes at E1 -> rsp_valid=1 after E2. Capture happens at edge E2.
//  Throughput: one operation per 4 cycles minimum (IDLE, EXEC, CAPT, RESP).
//  After CAPT, alu_ctrl returns to IDLE_CTRL and alu_a/alu_b keep their values.
//  Response: rsp_* stable while rsp_valid && !rsp_ready.
//    Handshake completes on the edge where rsp_valid && rsp_ready; rsp_valid then drops to 0.
//    rsp_r is held at its last value.
//  Backpressure: while in RESP, new requests wait; reqX_ready=0 and no request is dropped.
//  Reset mid-operation: in-flight operation discarded with no response; requester must re-issue.
//  Width: no arithmetic here; ovf/branch are taken verbatim from the ALU.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: fixed priority; req0 always wins when both are valid.
//    last_grant is not used; req1 can starve.
//  ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  1. Reset, then req0 alone: A=5, B=3, ctrl=000 -> req0_ready 1 cycle; 2 edges later rsp_valid=1, rsp_id=0,
//     rsp_r=8, zero=0, ovf=0.
//  2. req1 alone: A=B=7, ctrl=011 -> rsp_id=1, rsp_branch=1.
//     Then req1 alone: A=7, B=8, ctrl=011 -> rsp_branch=0, rsp_zero=1.
//  3. Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 (first 0); each response tagged accordingly.
//     With ALU_ARB_FIXED_PRIO_EN -> all grants to 0.
//  4. rsp_ready=0 for 5 cycles while both requests pending -> rsp_* stable; reqX_ready stays 0.
//     Then rsp_ready=1 -> next grant 1 cycle after the handshake.
//  5. req0: A=32'hFFFFFFFF, B=1, ctrl=000 -> rsp_r=0, rsp_ovf=1, rsp_zero=1.
//     req0: A=0, B=1, ctrl=001 -> rsp_r=32'hFFFFFFFF, rsp_ovf=1.
//  6. Assert reset asynchronously during CAPT -> immediately rsp_valid=0, alu_ctrl=IDLE_CTRL;
//     after release, pending req0 is re-granted and completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one registered ALU between two requesters and returns the
//            captured result over a valid/ready response channel.
//            Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties);
//            otherwise ties are resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int                WIDTH     = 32,
  parameter int                CTRL_W    = 3,
  parameter logic [CTRL_W-1:0] IDLE_CTRL = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_r,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic              alu_branch,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_r,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              rsp_branch
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]    rsp_r_q, rsp_r_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic                rsp_branch_q, rsp_branch_d;
  logic                grant0;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid;
`else
  logic last_grant_q, last_grant_d;

  // req0 loses a tie only when it was the most recent winner
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == S_IDLE && (req0_valid || req1_valid)) last_grant_d = !grant0;
  end
`endif

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_r_d      = rsp_r_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_branch_d = rsp_branch_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = grant0;
          req1_ready = !grant0;
          alu_a_d    = grant0 ? req0_a    : req1_a;
          alu_b_d    = grant0 ? req0_b    : req1_b;
          alu_ctrl_d = grant0 ? req0_ctrl : req1_ctrl;
          rsp_id_d   = !grant0;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: state_d = S_CAPT;
      S_CAPT: begin
        // ALU output now reflects the operands sampled one edge earlier
        rsp_r_d      = alu_r;
        rsp_zero_d   = alu_zero;
        rsp_ovf_d    = alu_ovf;
        rsp_branch_d = alu_branch;
        rsp_valid_d  = 1'b1;
        alu_ctrl_d   = IDLE_CTRL;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= IDLE_CTRL;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_r_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_branch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_r_q      <= rsp_r_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_branch_q <= rsp_branch_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_r      = rsp_r_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_branch = rsp_branch_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with a registered
//            ALU model (add/sub/compare) attached to the ALU side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam logic [2:0] C_IDLE_CTRL = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, alu_ovf, alu_branch;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_ovf, rsp_branch;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_r;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_branch(alu_branch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_branch(rsp_branch)
  );

  // Registered ALU model: 000 add (carry as ovf), 001 sub (borrow as ovf), 011 equality compare
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_r <= '0; alu_zero <= 1'b1; alu_ovf <= 1'b0; alu_branch <= 1'b0;
    end else begin
      logic [32:0] t;
      logic        br;
      t = '0; br = 1'b0;
      case (alu_ctrl)
        3'b000:  t = {1'b0, alu_a} + {1'b0, alu_b};
        3'b001:  t = {1'b0, alu_a} - {1'b0, alu_b};
        3'b011:  begin br = (alu_a == alu_b); t = {32'd0, br}; end
        default: t = '0;
      endcase
      alu_r <= t[31:0]; alu_ovf <= t[32]; alu_zero <= (t[31:0] == 32'd0); alu_branch <= br;
    end
  end

  // Drive one request across its grant edge; returns the readies seen before the edge.
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                       output bit r0, output bit r1);
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c; end
    #1 r0 = req0_ready; r1 = req1_ready;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_grant(output bit ok, output bit id);
    ok = 1'b0; id = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (req0_ready || req1_ready) begin ok = 1'b1; id = req1_ready; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_r !== 32'd0 || rsp_zero !== 1'b0 ||
        rsp_ovf !== 1'b0 || rsp_branch !== 1'b0) begin
      fails++; $display("FAIL reset_rsp: got v=%b id=%b r=%h z=%b o=%b b=%b want all 0",
                        rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_ovf, rsp_branch);
    end
    vectors++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== C_IDLE_CTRL) begin
      fails++; $display("FAIL reset_alu: got a=%h b=%h ctrl=%b want 0 0 111", alu_a, alu_b, alu_ctrl);
    end
    @(negedge clk); reset = 1'b0; #1;
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
  endtask

  task automatic test_req0_add;
    bit r0, r1, ok;
    rsp_ready = 1'b1;
    issue(1'b0, 32'd5, 32'd3, 3'b000, r0, r1);
    vectors++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      fails++; $display("FAIL add_ready: got %b%b want 10", r0, r1);
    end
    vectors++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_ctrl !== 3'b000 || req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL add_drive: got a=%0d b=%0d ctrl=%b rdy=%b v=%b want 5 3 000 0 0",
                        alu_a, alu_b, alu_ctrl, req0_ready, rsp_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_early: got rsp_valid=%b want 0", rsp_valid); end
    @(negedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_r !== 32'd8 || rsp_zero !== 1'b0 ||
        rsp_ovf !== 1'b0 || alu_ctrl !== C_IDLE_CTRL) begin
      fails++; $display("FAIL add_rsp: got v=%b id=%b r=%0d z=%b o=%b ctrl=%b want 1 0 8 0 0 111",
                        rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_ovf, alu_ctrl);
    end
    @(negedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_r !== 32'd8 || alu_a !== 32'd5) begin
      fails++; $display("FAIL add_hs: got v=%b r=%0d a=%0d want 0 8 5", rsp_valid, rsp_r, alu_a);
    end
    ok = 1'b1;
  endtask

  task automatic test_req1_compare;
    bit r0, r1, ok;
    issue(1'b1, 32'd7, 32'd7, 3'b011, r0, r1);
    vectors++;
    if (r0 !== 1'b0 || r1 !== 1'b1) begin fails++; $display("FAIL cmp_ready: got %b%b want 01", r0, r1); end
    wait_rsp(ok);
    vectors++;
    if (!ok || rsp_id !== 1'b1 || rsp_branch !== 1'b1 || rsp_zero !== 1'b0) begin
      fails++; $display("FAIL cmp_eq: got ok=%b id=%b br=%b z=%b want 1 1 1 0", ok, rsp_id, rsp_branch, rsp_zero);
    end
    @(negedge clk);
    issue(1'b1, 32'd7, 32'd8, 3'b011, r0, r1);
    wait_rsp(ok);
    vectors++;
    if (!ok || rsp_id !== 1'b1 || rsp_branch !== 1'b0 || rsp_zero !== 1'b1) begin
      fails++; $display("FAIL cmp_ne: got ok=%b id=%b br=%b z=%b want 1 1 0 1", ok, rsp_id, rsp_branch, rsp_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    bit ok, gid, exp_id;
    logic [31:0] exp_r;
    rsp_ready = 1'b1;
    req0_a = 32'd10; req0_b = 32'd1; req0_ctrl = 3'b000;
    req1_a = 32'd20; req1_b = 32'd2; req1_ctrl = 3'b001;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = i[0];
`endif
      exp_r = exp_id ? 32'd18 : 32'd11;
      wait_grant(ok, gid);
      vectors++;
      if (!ok || gid !== exp_id || (req0_ready && req1_ready)) begin
        fails++; $display("FAIL rr_grant[%0d]: got ok=%b id=%b rdy=%b%b want id=%b", i, ok, gid,
                          req0_ready, req1_ready, exp_id);
      end
      @(negedge clk); #1;
      wait_rsp(ok);
      if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      vectors++;
      if (!ok || rsp_id !== exp_id || rsp_r !== exp_r) begin
        fails++; $display("FAIL rr_rsp[%0d]: got ok=%b id=%b r=%0d want id=%b r=%0d", i, ok, rsp_id, rsp_r, exp_id, exp_r);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    bit ok, gid, exp_id;
    logic [31:0] held_r;
    logic        held_id;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    wait_grant(ok, gid);
    @(negedge clk); #1;
    wait_rsp(ok);
    vectors++;
    if (!ok || rsp_id !== 1'b0) begin fails++; $display("FAIL bp_first: got ok=%b id=%b want 1 0", ok, rsp_id); end
    held_r = rsp_r; held_id = rsp_id;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_r !== held_r || rsp_id !== held_id || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d]: got v=%b r=%0d id=%b rdy=%b%b want 1 %0d %b 00",
                          i, rsp_valid, rsp_r, rsp_id, req0_ready, req1_ready, held_r, held_id);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_id = 1'b0;
`else
    exp_id = 1'b1;
`endif
    vectors++;
    if (rsp_valid !== 1'b0 || req0_ready !== !exp_id || req1_ready !== exp_id) begin
      fails++; $display("FAIL bp_regrant: got v=%b rdy=%b%b want v=0 id=%b", rsp_valid, req0_ready, req1_ready, exp_id);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    wait_rsp(ok);
    vectors++;
    if (!ok || rsp_id !== exp_id) begin fails++; $display("FAIL bp_second: got ok=%b id=%b want id=%b", ok, rsp_id, exp_id); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    bit r0, r1, ok;
    rsp_ready = 1'b1;
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b000, r0, r1);
    wait_rsp(ok);
    vectors++;
    if (!ok || rsp_r !== 32'd0 || rsp_ovf !== 1'b1 || rsp_zero !== 1'b1) begin
      fails++; $display("FAIL ovf_add: got ok=%b r=%h o=%b z=%b want 0 1 1", ok, rsp_r, rsp_ovf, rsp_zero);
    end
    @(negedge clk);
    issue(1'b0, 32'd0, 32'd1, 3'b001, r0, r1);
    wait_rsp(ok);
    vectors++;
    if (!ok || rsp_r !== 32'hFFFF_FFFF || rsp_ovf !== 1'b1 || rsp_zero !== 1'b0) begin
      fails++; $display("FAIL ovf_sub: got ok=%b r=%h o=%b z=%b want ffffffff 1 0", ok, rsp_r, rsp_ovf, rsp_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    bit ok;
    rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_ctrl = 3'b000;
    @(negedge clk);
    @(negedge clk);
    // now in CAPT; the request stays pending across the reset
    reset = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || alu_ctrl !== C_IDLE_CTRL || alu_a !== 32'd0) begin
      fails++; $display("FAIL rst_mid: got v=%b ctrl=%b a=%0d want 0 111 0", rsp_valid, alu_ctrl, alu_a);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL rst_regrant: got rdy=%b v=%b want 1 0", req0_ready, rsp_valid);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    wait_rsp(ok);
    vectors++;
    if (!ok || rsp_id !== 1'b0 || rsp_r !== 32'd4) begin
      fails++; $display("FAIL rst_complete: got ok=%b id=%b r=%0d want 1 0 4", ok, rsp_id, rsp_r);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_req0_add;
    test_req1_compare;
    test_round_robin;
    test_backpressure;
    test_overflow;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
